// File: rtl/uart_autobaud.sv
// Auto-baud detector: times a 0x55 sync character on the synchronized RX line
// and derives the 16-bit baud NCO increment as floor(2^23 / C).
module uart_autobaud #(
  parameter int CntW   = 20,
  parameter int MinCnt = 128
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            rx_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            nco_we_o,
  output logic [15:0]     nco_o,
  output logic [CntW-1:0] cnt_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    MEAS = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [CntW-1:0] CNT_MAX = {CntW{1'b1}};
  localparam logic [CntW-1:0] MIN_C   = CntW'(MinCnt);
  localparam logic [CntW-1:0] CNT_ONE = CntW'(1);
  localparam logic [CntW-1:0] CNT_ZERO = {CntW{1'b0}};

  state_t          state_r, state_s;
  logic            rx_q_r;
  logic [CntW-1:0] tot_r, tot_s;
  logic [CntW-1:0] int_r, int_s;
  logic [2:0]      edge_r, edge_s;
  logic [CntW-1:0] i1_r, i1_s;
  logic            err_r, err_s;
  logic [CntW-1:0] c_r, c_s;
  logic [CntW-1:0] rem_r, rem_s;
  logic [22:0]     quo_r, quo_s;
  logic [4:0]      step_r, step_s;

  logic            fall_s;
  logic [CntW-1:0] tot_inc_s, int_inc_s, diff_s;
  logic            bad_s;
  logic [CntW:0]   rem_sh_s;
  logic            ge_s;
  logic [23:0]     quo_full_s;

  function automatic logic [15:0] sat16(input logic [23:0] q);
    return (q[23:16] != 8'h00) ? 16'hFFFF : q[15:0];
  endfunction

  // Counter values "as of this cycle", interval check and one divider step
  always_comb begin
    fall_s     = rx_q_r & ~rx_i;
    tot_inc_s  = tot_r + CNT_ONE;
    int_inc_s  = int_r + CNT_ONE;
    diff_s     = (int_inc_s >= i1_r) ? (int_inc_s - i1_r) : (i1_r - int_inc_s);
    bad_s      = (diff_s > (i1_r >> 3));
    rem_sh_s   = {rem_r, (step_r == 5'd0)};
    ge_s       = (rem_sh_s >= {1'b0, c_r});
    quo_full_s = {quo_r, ge_s};
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    tot_s   = tot_r;
    int_s   = int_r;
    edge_s  = edge_r;
    i1_s    = i1_r;
    err_s   = err_r;
    c_s     = c_r;
    rem_s   = rem_r;
    quo_s   = quo_r;
    step_s  = step_r;
    case (state_r)
      IDLE: begin
        if (start_i) state_s = ARM;
        else         state_s = IDLE;
      end
      ARM: begin
        if (fall_s) begin
          tot_s   = CNT_ZERO;
          int_s   = CNT_ZERO;
          edge_s  = 3'd1;
          err_s   = 1'b0;
          state_s = MEAS;
        end else begin
          state_s = ARM;
        end
      end
      MEAS: begin
        tot_s = tot_inc_s;
        int_s = int_inc_s;
        // Saturation wins over an edge landing on the same cycle
        if (tot_inc_s == CNT_MAX) begin
          err_s   = 1'b1;
          c_s     = CNT_MAX;
          state_s = DONE;
        end else if (fall_s) begin
          edge_s = edge_r + 3'd1;
          int_s  = CNT_ZERO;
          if (edge_r == 3'd1) i1_s  = int_inc_s;
          else                err_s = err_r | bad_s;
          if (edge_r == 3'd4) begin
            c_s     = tot_inc_s;
            err_s   = err_s | (tot_inc_s < MIN_C);
            rem_s   = CNT_ZERO;
            quo_s   = 23'd0;
            step_s  = 5'd0;
            state_s = DIV;
          end else begin
            state_s = MEAS;
          end
        end else begin
          state_s = MEAS;
        end
      end
      DIV: begin
        rem_s  = ge_s ? (rem_sh_s[CntW-1:0] - c_r) : rem_sh_s[CntW-1:0];
        quo_s  = quo_full_s[22:0];
        step_s = step_r + 5'd1;
        if (step_r == 5'd23) state_s = DONE;
        else                 state_s = DIV;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (abort_i) state_s = IDLE;
    else         state_s = state_s;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      rx_q_r   <= 1'b1;
      tot_r    <= CNT_ZERO;
      int_r    <= CNT_ZERO;
      edge_r   <= 3'd0;
      i1_r     <= CNT_ZERO;
      err_r    <= 1'b0;
      c_r      <= CNT_ZERO;
      rem_r    <= CNT_ZERO;
      quo_r    <= 23'd0;
      step_r   <= 5'd0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      nco_we_o <= 1'b0;
      nco_o    <= 16'h0000;
      cnt_o    <= CNT_ZERO;
    end else begin
      state_r  <= state_s;
      rx_q_r   <= rx_i;
      tot_r    <= tot_s;
      int_r    <= int_s;
      edge_r   <= edge_s;
      i1_r     <= i1_s;
      err_r    <= err_s;
      c_r      <= c_s;
      rem_r    <= rem_s;
      quo_r    <= quo_s;
      step_r   <= step_s;
      busy_o   <= (state_s != IDLE);
      done_o   <= (state_s == DONE);
      err_o    <= (state_s == DONE) & err_s;
      nco_we_o <= (state_s == DONE) & ~err_s;
      if (state_s == DONE) cnt_o <= c_s;
      else                 cnt_o <= cnt_o;
      // Divide is on its last step when DONE is entered without error
      if ((state_s == DONE) && !err_s) nco_o <= sat16(quo_full_s);
      else                             nco_o <= nco_o;
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: drives 0x55 frames, predicts the
// outcome with a reference model and compares at done_o via a scoreboard queue.
module tb_uart_autobaud;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, rx;
  logic        busy, done, err, nco_we;
  logic [15:0] nco;
  logic [19:0] cnt;

  logic        start2, abort2, rx2;
  logic        busy2, done2, err2, nco_we2;
  logic [15:0] nco2;
  logic [11:0] cnt2;

  uart_autobaud dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .rx_i(rx),
    .busy_o(busy), .done_o(done), .err_o(err), .nco_we_o(nco_we),
    .nco_o(nco), .cnt_o(cnt)
  );

  uart_autobaud #(.CntW(12)) dut12 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(abort2), .rx_i(rx2),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .nco_we_o(nco_we2),
    .nco_o(nco2), .cnt_o(cnt2)
  );

  typedef struct {
    logic        err;
    logic [15:0] nco;
    logic [19:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] nco_model = 16'h0000;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: intervals 2T, 2T+d, 2T-d, 2T; C = 8T; NCO = min(floor(2^23/C), 0xFFFF)
  function automatic exp_t model(input int tbit, input int dly, input logic [15:0] prev);
    exp_t e;
    int   i1, c, q;
    int   iv[3];
    i1 = 2 * tbit;
    iv[0] = 2 * tbit + dly;
    iv[1] = 2 * tbit - dly;
    iv[2] = 2 * tbit;
    c = 8 * tbit;
    e.err = (c < 128);
    for (int k = 0; k < 3; k++)
      if (iabs(iv[k] - i1) > (i1 / 8)) e.err = 1'b1;
    q = (1 << 23) / c;
    if (q > 65535) q = 65535;
    e.nco = e.err ? prev : q[15:0];
    e.cnt = c[19:0];
    return e;
  endfunction

  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hold(1'b1, 4);
  endtask

  // Start bit through d6; leaves rx low at the 5th falling edge (d7)
  task automatic send_to_fifth(input int tbit, input int dly);
    hold(1'b0, tbit);
    hold(1'b1, tbit); hold(1'b0, tbit);
    hold(1'b1, tbit + dly); hold(1'b0, tbit - dly);
    hold(1'b1, tbit); hold(1'b0, tbit);
    hold(1'b1, tbit);
    rx = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done got %0b exp 0", done); end
    n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL reset_err got %0b exp 0", err); end
    n_cmp++; if (nco_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %0b exp 0", nco_we); end
    n_cmp++; if (nco !== 16'h0)   begin n_bad++; $display("FAIL reset_nco got %0h exp 0", nco); end
    n_cmp++; if (cnt !== 20'h0)   begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    rst = 1'b0;
    hold(1'b1, 5);
  endtask

  task automatic test_frame(input string name, input int tbit, input int dly);
    exp_t e, got;
    int   n;
    bit   seen;
    e = model(tbit, dly, nco_model);
    if (!e.err) nco_model = e.nco;
    sb.push_back(e);
    pulse_start();
    send_to_fifth(tbit, dly);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == tbit) rx = 1'b1;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    got = sb.pop_front();
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL %s_timeout no done_o within 200 cycles", name);
    end else begin
      if (n !== 25) begin n_bad++; $display("FAIL %s_latency got %0d exp 25", name, n); end
      n_cmp++; if (err !== got.err) begin n_bad++; $display("FAIL %s_err got %0b exp %0b", name, err, got.err); end
      n_cmp++; if (nco_we !== ~got.err) begin n_bad++; $display("FAIL %s_we got %0b exp %0b", name, nco_we, ~got.err); end
      n_cmp++; if (nco !== got.nco) begin n_bad++; $display("FAIL %s_nco got %0d exp %0d", name, nco, got.nco); end
      n_cmp++; if (cnt !== got.cnt) begin n_bad++; $display("FAIL %s_cnt got %0d exp %0d", name, cnt, got.cnt); end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || nco_we !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL %s_pulse done=%0b we=%0b busy=%0b exp 0", name, done, nco_we, busy);
      end
      n_cmp++; if (nco !== got.nco) begin n_bad++; $display("FAIL %s_hold got %0d exp %0d", name, nco, got.nco); end
    end
    @(posedge clk); #1;
    hold(1'b1, 3 * tbit + 20);
  endtask

  task automatic test_abort;
    bit seen;
    pulse_start();
    hold(1'b0, 434);
    hold(1'b1, 434); hold(1'b0, 434);
    hold(1'b1, 434);
    hold(1'b0, 100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %0b exp 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || nco_we) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_done got pulse exp none"); end
    n_cmp++; if (nco !== nco_model) begin n_bad++; $display("FAIL abort_nco got %0d exp %0d", nco, nco_model); end
    @(posedge clk); #1;
    hold(1'b1, 500);
    test_frame("after_abort", 434, 0);
  endtask

  task automatic test_timeout;
    exp_t e, got;
    int   n;
    bit   seen;
    e.err = 1'b1; e.nco = 16'h0000; e.cnt = 20'd4095;
    sb.push_back(e);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rx2 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
      if (done2) seen = 1'b1;
    end
    got = sb.pop_front();
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL sat_timeout no done_o within 5000 cycles");
    end else begin
      if (n !== 4096) begin n_bad++; $display("FAIL sat_latency got %0d exp 4096", n); end
      n_cmp++; if (err2 !== got.err) begin n_bad++; $display("FAIL sat_err got %0b exp %0b", err2, got.err); end
      n_cmp++; if (nco_we2 !== 1'b0) begin n_bad++; $display("FAIL sat_we got %0b exp 0", nco_we2); end
      n_cmp++; if (cnt2 !== got.cnt[11:0]) begin n_bad++; $display("FAIL sat_cnt got %0d exp %0d", cnt2, got.cnt); end
      n_cmp++; if (nco2 !== got.nco) begin n_bad++; $display("FAIL sat_nco got %0d exp %0d", nco2, got.nco); end
    end
    @(posedge clk); #1;
    rx2 = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid_div;
    pulse_start();
    send_to_fifth(16, 0);
    repeat (10) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL middiv_busy got %0b exp 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || nco_we !== 1'b0) begin
      n_bad++; $display("FAIL middiv_flags busy=%0b done=%0b err=%0b we=%0b exp 0", busy, done, err, nco_we);
    end
    n_cmp++; if (nco !== 16'h0) begin n_bad++; $display("FAIL middiv_nco got %0d exp 0", nco); end
    n_cmp++; if (cnt !== 20'h0) begin n_bad++; $display("FAIL middiv_cnt got %0d exp 0", cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    hold(1'b1, 10);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rx = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; rx2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_frame("b115200", 434, 0);
    test_frame("tbit15", 15, 0);
    test_frame("tbit16", 16, 0);
    test_frame("d3_late", 434, 120);
    test_abort();
    test_timeout();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_autobaud.md
Name: uart_autobaud

Overview:
- Measures the bit period of a 0x55 sync character on the synchronized RX line and computes the 16-bit NCO increment for the UART baud generator (ctrl.nco).
- Sits upstream of the UART core. Its rx_i is taken after the 2-flop synchronizer.
- Its nco_o / nco_we_o feed the register block's hardware-write path into ctrl.nco.
- The NCO relation is tick_x16 rate = Fclk*NCO/2^16, hence NCO = 2^23 / C, where C = clocks spanning 8 bit periods.

Parameters:
- CntW, 20, width of the total-span counter C; saturation at 2^CntW-1 is a timeout.
- MinCnt, 128, minimum legal C. A smaller C flags an error (baud too high for NCO precision).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  pulse; arms a measurement; ignored unless state is IDLE
- abort_i  in  1  level/pulse; returns to IDLE from any state; no done_o
- rx_i  in  1  synchronized RX line, idle high
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at end of measurement (success or error)
- err_o  out  1  valid with done_o; 1 = measurement rejected
- nco_we_o  out  1  one-cycle pulse = done_o & ~err_o; write strobe for ctrl.nco
- nco_o  out  16  last successful NCO value; held between measurements
- cnt_o  out  CntW  last measured C (also updated on error); debug/status

Behaviour:
- Reset values: busy_o=0, done_o=0, err_o=0, nco_we_o=0, nco_o=16'h0, cnt_o=0, state=IDLE, rx_q=1.
- Edge detect: rx_q <= rx_i every cycle. fall = rx_q & ~rx_i.
- Sync pattern 0x55 LSB-first gives falling edges at start, d1, d3, d5, d7. Five edges span exactly 8 bit periods.
- States: IDLE, ARM, MEAS, DIV, DONE.
- IDLE:
  - start_i -> ARM.
  - abort_i has priority over start_i.
- ARM:
  - Waits indefinitely for fall.
  - On fall: total counter=0, interval counter=0, edge_cnt=1 -> MEAS.
- MEAS:
  - Total and interval counters increment every cycle.
  - On fall, edge_cnt increments and the interval I_k (counter value at the edge, i.e. cycles since the previous edge) is captured.
  - I_1 is stored.
  - For k=2..4: error flag set if |I_k - I_1| > (I_1 >> 3).
  - On the 5th fall: C = total count at that cycle (cycles between 1st and 5th edge cycles) -> DIV.
  - If the total counter reaches 2^CntW-1 before the 5th edge: error flag set, C = 2^CntW-1 -> DONE (divide skipped).
  - A fall on the same cycle as saturation counts as an edge; saturation still wins.
- DIV:
  - Restoring divide of 24-bit dividend 2^23 by C (CntW bits), 1 quotient bit per cycle, exactly 24 cycles.
  - C < MinCnt: error flag set, divide still runs (fixed latency).
  - Quotient > 16'hFFFF saturates to 16'hFFFF (not an error).
  - Result is truncated (floor), no rounding.
- DONE:
  - Single cycle: done_o=1, err_o=error flag, cnt_o=C.
  - If no error: nco_o=quotient and nco_we_o=1.
  - Next state is IDLE.
- Latency: done_o is high exactly 25 cycles after the cycle where the 5th falling edge is sampled. Timeout path: done_o is high the cycle after saturation.
- Outputs done_o / err_o / nco_we_o are registered. nco_o changes only in the same cycle nco_we_o is high.
- Simultaneous events:
  - abort_i in any state -> IDLE next cycle; no outputs pulsed; nco_o unchanged.
  - abort_i in DONE suppresses nothing, since DONE already drives outputs that cycle.
  - start_i while busy is ignored.
- A rising/falling glitch shorter than one clock cannot occur, because rx_i is synchronized. Any noise edge counts as an edge and is caught by the interval check.
- Reset mid-operation: immediately returns to reset values. nco_o is cleared to 0; the register block keeps its own copy.
- Divider and counters use unsigned arithmetic. The interval difference is computed as an unsigned absolute value with width CntW.

Test Plan:
- Tbit=434 clocks (115200 baud @50 MHz), start_i, clean 0x55 frame:
  - C=3472, nco_o=2416 (0x0970), nco_we_o pulse, err_o=0.
  - done_o exactly 25 cycles after 5th falling edge.
- Tbit=16, clean 0x55: C=128, quotient 65536 -> nco_o=16'hFFFF, err_o=0.
- Tbit=15:
  - C=120 < MinCnt -> err_o=1, nco_we_o=0, nco_o keeps previous value (2416 from prior test), cnt_o=120.
- Tbit=434 with the d3 falling edge delayed 120 clocks:
  - I_2 = 988 vs I_1 = 868 exceeds 108 -> err_o=1, nco_o unchanged.
- Line held low after first edge (CntW=12 build):
  - saturation at 4095 -> done_o next cycle, err_o=1, cnt_o=4095.
- Abort and reset cases:
  - abort_i during MEAS after 3rd edge -> busy_o=0 next cycle, no done_o; a subsequent start_i plus clean frame measures correctly.
  - rst_i asserted mid-DIV -> all outputs 0 immediately.
